atmega_uart_bus_master: RTL and testbench

//  Bus initiator for the ATmega-style UART register map (UDR/UCSRA/UCSRB), e.g. atmega_usb2uart.

---
 rtl/atmega_uart_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_atmega_uart_bus_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_uart_bus_master.sv
// atmega_uart_bus_master: firmware-free bus initiator for an ATmega-style UART register map.
// It enables RX/TX once, then polls UCSRA. Received bytes are drained from UDR into a
// valid/ready output stream. Bytes from a valid/ready input stream are written to UDR
// whenever the transmitter reports UDRE.
module atmega_uart_bus_master #(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR        = 'hc9,
    parameter int unsigned                  SETTLE_CYCLES     = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    // I/O bus
    output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
    output logic                         wr_o,
    output logic                         rd_o,
    output logic [7:0]                   bus_o,
    input  logic [7:0]                   bus_i,
    // Transmit stream
    input  logic [7:0]                   tx_data_i,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    // Receive stream
    output logic [7:0]                   rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i
);

    // UCSRA status bits and the UCSRB enable value (RXEN | TXEN)
    localparam int unsigned RxcBit    = 7;
    localparam int unsigned UdreBit   = 5;
    localparam logic [7:0]  UcsrbInit = 8'h18;

    localparam int unsigned         CntW      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0]     SettleMax = CntW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        StInit,
        StSettle,
        StPoll,
        StRdUdr,
        StWrUdr
    } state_e;

    state_e                         state_q, state_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic                           prio_tx_q, prio_tx_d;   // 0: RX wins a tie, 1: TX wins
    logic [BUS_ADDR_DATA_LEN-1:0]   addr_q, addr_d;
    logic                           wr_q, wr_d;
    logic                           rd_q, rd_d;
    logic [7:0]                     bus_q, bus_d;
    logic [7:0]                     rx_data_q, rx_data_d;
    logic                           rx_valid_q, rx_valid_d;
    logic [7:0]                     tx_data_q, tx_data_d;
    logic                           tx_ready_q, tx_ready_d;

    logic                           rx_ok;
    logic                           tx_ok;

    // Status decode, only meaningful while the UCSRA read is on the bus
    always_comb begin
        rx_ok = bus_i[RxcBit] & ~rx_valid_q;
        tx_ok = bus_i[UdreBit] & ~tx_ready_q;
    end

    // Next-state logic: stream handshakes first, then the bus sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_tx_d  = prio_tx_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        bus_d      = bus_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_data_d  = tx_data_q;
        tx_ready_d = tx_ready_q;

        // Consumer takes the received byte
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        // Producer hands over a byte to the empty holding register
        if (tx_valid_i && tx_ready_q) begin
            tx_data_d  = tx_data_i;
            tx_ready_d = 1'b0;
        end

        // Strobes are registered, so each access is issued one state ahead of the
        // state that represents its bus cycle.
        unique case (state_q)
            StInit: begin
                wr_d    = 1'b1;
                addr_d  = UCSRB_ADDR;
                bus_d   = UcsrbInit;
                // The UCSRB write is on the bus during the first SETTLE cycle,
                // so the count starts at zero here.
                cnt_d   = '0;
                state_d = StSettle;
            end

            StSettle: begin
                if (cnt_q != SettleMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end else if (enable_i) begin
                    rd_d    = 1'b1;
                    addr_d  = UCSRA_ADDR;
                    state_d = StPoll;
                end
            end

            StPoll: begin
                // Access cycle already counts as settle cycle zero
                cnt_d   = CntW'(1);
                state_d = StSettle;
                if (rx_ok && (!tx_ok || !prio_tx_q)) begin
                    rd_d    = 1'b1;
                    addr_d  = UDR_ADDR;
                    state_d = StRdUdr;
                end else if (tx_ok) begin
                    wr_d    = 1'b1;
                    addr_d  = UDR_ADDR;
                    bus_d   = tx_data_q;
                    state_d = StWrUdr;
                end
                // Alternate only when both sides competed
                if (rx_ok && tx_ok) begin
                    prio_tx_d = ~prio_tx_q;
                end
            end

            StRdUdr: begin
                // rx_valid_q is known clear here: RD_UDR is only entered with rx empty
                rx_data_d  = bus_i;
                rx_valid_d = 1'b1;
                cnt_d      = CntW'(1);
                state_d    = StSettle;
            end

            StWrUdr: begin
                // Holding register is full during this state, so no accept can collide
                tx_ready_d = 1'b1;
                cnt_d      = CntW'(1);
                state_d    = StSettle;
            end

            default: begin
                state_d = StInit;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            prio_tx_q  <= 1'b0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            bus_q      <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_tx_q  <= prio_tx_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            bus_q      <= bus_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        addr_o     = addr_q;
        wr_o       = wr_q;
        rd_o       = rd_q;
        bus_o      = bus_q;
        rx_data_o  = rx_data_q;
        rx_valid_o = rx_valid_q;
        tx_ready_o = tx_ready_q;
    end

endmodule

// File: tb/tb_atmega_uart_bus_master.sv
// Directed bench for atmega_uart_bus_master with a simple combinational register responder.
module tb_atmega_uart_bus_master;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] bus_out;
    logic [7:0] bus_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    logic [7:0] ucsra_val;
    logic [7:0] udr_val;

    int n_tests;
    int n_fail;
    int udr_rd_cnt;

    atmega_uart_bus_master dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .addr_o     (addr),
        .wr_o       (wr),
        .rd_o       (rd),
        .bus_o      (bus_out),
        .bus_i      (bus_in),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: read data is combinational on address during the read strobe
    always_comb begin
        bus_in = 8'h00;
        if (rd && addr == 8'hc8) bus_in = ucsra_val;
        else if (rd && addr == 8'hc1) bus_in = udr_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd && addr == 8'hc1) udr_rd_cnt++;
    endtask

    // Advance until a UCSRA poll is on the bus; n is the number of ticks taken
    task automatic wait_poll(input string tag, output int n);
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            seen = rd && addr == 8'hc8;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic offer_tx(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        check("tx_accept", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
    endtask

    initial begin
        int n;
        int polls;
        int held;
        int rd_before;
        n_tests    = 0;
        n_fail     = 0;
        udr_rd_cnt = 0;
        rst        = 1'b1;
        enable     = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        ucsra_val  = 8'h00;
        udr_val    = 8'h00;

        // Reset values
        tick();
        tick();
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_rd", {31'd0, rd}, 32'd0);
        check("rst_addr", {24'd0, addr}, 32'h00);
        check("rst_bus", {24'd0, bus_out}, 32'h00);
        check("rst_rxv", {31'd0, rx_valid}, 32'd0);
        check("rst_rxd", {24'd0, rx_data}, 32'h00);
        check("rst_txr", {31'd0, tx_ready}, 32'd1);

        // 1: INIT write, 3 idle cycles, then UCSRA poll
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("init_wr", {31'd0, wr}, 32'd1);
        check("init_addr", {24'd0, addr}, 32'hc9);
        check("init_bus", {24'd0, bus_out}, 32'h18);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("init_idle", {30'd0, wr, rd}, 32'd0);
        end
        tick();
        check("poll1_rd", {31'd0, rd}, 32'd1);
        check("poll1_addr", {24'd0, addr}, 32'hc8);

        // 2: TX byte 41 written when UDRE set
        tick();
        offer_tx(8'h41);
        ucsra_val = 8'h20;
        wait_poll("poll_tx", n);
        tick();
        check("wr_udr_wr", {31'd0, wr}, 32'd1);
        check("wr_udr_rd", {31'd0, rd}, 32'd0);
        check("wr_udr_addr", {24'd0, addr}, 32'hc1);
        check("wr_udr_bus", {24'd0, bus_out}, 32'h41);
        check("wr_udr_txr", {31'd0, tx_ready}, 32'd0);
        ucsra_val = 8'h00;
        tick();
        check("tx_ready_back", {31'd0, tx_ready}, 32'd1);
        check("wr_one_cycle", {31'd0, wr}, 32'd0);

        // 3: RX byte 5A drained and held under backpressure
        ucsra_val = 8'h80;
        udr_val   = 8'h5a;
        wait_poll("poll_rx", n);
        tick();
        check("rd_udr_rd", {31'd0, rd}, 32'd1);
        check("rd_udr_addr", {24'd0, addr}, 32'hc1);
        tick();
        check("rx_valid", {31'd0, rx_valid}, 32'd1);
        check("rx_data", {24'd0, rx_data}, 32'h5a);
        // 5: RXC still set while full: held, no UDR reads, polls every 4 cycles
        rd_before = udr_rd_cnt;
        held      = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rx_valid && rx_data == 8'h5a) held++;
        end
        check("rx_held10", held, 10);
        wait_poll("poll_bp_a", n);
        wait_poll("poll_bp_b", n);
        check("poll_period", n, 4);
        check("no_udr_read", udr_rd_cnt - rd_before, 0);
        ucsra_val = 8'h00;
        rx_ready  = 1'b1;
        tick();
        check("rx_cleared", {31'd0, rx_valid}, 32'd0);

        // 4: both sides ready twice: RX first, then TX
        offer_tx(8'h33);
        ucsra_val = 8'ha0;
        udr_val   = 8'h77;
        wait_poll("poll_both1", n);
        tick();
        check("alt1_rd", {31'd0, rd}, 32'd1);
        check("alt1_addr", {24'd0, addr}, 32'hc1);
        tick();
        check("alt1_data", {24'd0, rx_data}, 32'h77);
        wait_poll("poll_both2", n);
        tick();
        check("alt2_wr", {31'd0, wr}, 32'd1);
        check("alt2_bus", {24'd0, bus_out}, 32'h33);
        ucsra_val = 8'h00;
        rx_ready  = 1'b0;
        tick();
        check("alt2_txr", {31'd0, tx_ready}, 32'd1);

        // enable low parks the sequencer in SETTLE
        enable = 1'b0;
        tick();
        tick();
        polls = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd || wr) polls++;
        end
        check("parked", polls, 0);
        enable = 1'b1;

        // 6: fill RX, then reset during a UDR write
        ucsra_val = 8'h80;
        udr_val   = 8'h99;
        wait_poll("poll_fill", n);
        tick();
        tick();
        check("fill_rxv", {31'd0, rx_valid}, 32'd1);
        check("fill_rxd", {24'd0, rx_data}, 32'h99);
        offer_tx(8'h55);
        ucsra_val = 8'ha0;
        wait_poll("poll_pre_rst", n);
        tick();
        check("pre_rst_wr", {31'd0, wr}, 32'd1);
        check("pre_rst_bus", {24'd0, bus_out}, 32'h55);
        rst = 1'b1;
        #1;
        check("mid_rst_wr", {31'd0, wr}, 32'd0);
        check("mid_rst_rxv", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_txr", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_addr", {24'd0, addr}, 32'h00);
        ucsra_val = 8'h00;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("reinit_wr", {31'd0, wr}, 32'd1);
        check("reinit_addr", {24'd0, addr}, 32'hc9);
        check("reinit_bus", {24'd0, bus_out}, 32'h18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
